datamem_ctrl: RTL and testbench
===============================

Name: datamem_ctrl

Overview:
- Data-memory controller sitting directly downstream of the main control unit's load/store handshake.
- Accepts a level-held load request (control unit's data-memory ready output) or a store request (its data-memory valid output).
- Drives a single-port synchronous word-wide SRAM with byte enables.
- Returns a one-cycle response pulse: load-valid, or store-ready. Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW lane selection, sign/zero extension and misalignment detection.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width (memory = 2^ADDR_WIDTH x 32 bits).
- MEM_LATENCY, 1, edges from the edge sampling DMC_Mem_Re high to the edge at which DMC_Mem_Rdata is sampled; legal range 1..7.

Ports:
- DMC_Clk  in  1  clock; all logic on rising edge.
- DMC_Reset  in  1  synchronous, active-high reset.
- DMC_Load_Req  in  1  load request, level, held until DMC_Load_Valid seen.
- DMC_Store_Req  in  1  store request, level, held until DMC_Store_Ready seen.
- DMC_Funct3  in  3  instruction funct3 (width/sign).
- DMC_Addr  in  32  byte address (rs1+imm).
- DMC_Wdata  in  32  store data (rs2).
- DMC_Load_Valid  out  1  one-cycle load-complete pulse.
- DMC_Store_Ready  out  1  one-cycle store-complete pulse.
- DMC_Rdata  out  32  extended load result; held until next accepted request.
- DMC_Misaligned  out  1  set with the response pulse when the access was misaligned or funct3 was illegal; held like DMC_Rdata.
- DMC_Mem_Addr  out  ADDR_WIDTH  word address = DMC_Addr[ADDR_WIDTH+1:2].
- DMC_Mem_Re  out  1  SRAM read strobe.
- DMC_Mem_We  out  1  SRAM write strobe.
- DMC_Mem_Be  out  4  byte enables.
- DMC_Mem_Wdata  out  32  lane-shifted write data.
- DMC_Mem_Rdata  in  32  SRAM read data.

Behaviour:
- All outputs are registered. Sync reset (DMC_Reset=1 at an edge) forces:
  - state IDLE;
  - every output 0, including Rdata, Misaligned, Mem_Addr, Be and Wdata;
  - latency counter 0.
- Reset mid-operation abandons the access; no response pulse is issued.
- States:
  - IDLE: wait for a request.
  - READ: counter runs MEM_LATENCY-1 down to 0.
  - WRITE
  - RESP: one cycle.
  - HOLD: wait until both requests are low.
- IDLE:
  - Load_Req=1 has priority over Store_Req=1; it latches Addr/Funct3.
  - Legal and aligned request: go READ (Mem_Re=1 for exactly one cycle) or WRITE (Mem_We=1 for exactly one cycle, with Be/Wdata).
  - Otherwise go RESP directly: no SRAM strobe, Misaligned=1, Rdata=0.
- Legal load funct3: 0, 1, 2, 4, 5. Legal store funct3: 0, 1, 2.
- Misaligned: halfword with Addr[0]=1; word with Addr[1:0]!=0.
- Store lane rules:
  - SB: Be = 1<<Addr[1:0]; Wdata = {4{Wdata[7:0]}}.
  - SH: Be = 0011 or 1100 by Addr[1]; Wdata = {2{Wdata[15:0]}}.
  - SW: Be = 1111.
- Load extraction: byte/half selected by the latched Addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Load timing: request sampled at edge E0.
  - Mem_Re is high between E0 and E1.
  - Mem_Rdata is captured at E(1+MEM_LATENCY).
  - Load_Valid is high for the one cycle after that edge.
  - Total: MEM_LATENCY+2 cycles from the request edge to the pulse.
- Store timing: Mem_We is high between E0 and E1; Store_Ready is high between E1 and E2.
- Error response: pulse appears between E0 and E1.
- RESP always goes to HOLD. HOLD returns to IDLE only when Load_Req=0 and Store_Req=0, so a held request never triggers a second access.
- Only one pulse (Load_Valid or Store_Ready) per request, matching the request type.

Test Plan:
- Reset: DMC_Reset=1 for 2 edges while Load_Req=1 -> all outputs 0. Release -> Mem_Re pulses once on the next edge.
- LW, MEM_LATENCY=1: Addr=0x0000_0008, SRAM word 2 = 0xDEAD_BEEF -> Mem_Addr=2, Mem_Re for 1 cycle, Load_Valid exactly 3 cycles after request edge, Rdata=0xDEAD_BEEF, Misaligned=0.
- LB/LBU/LH: SRAM word = 0x80F0_7F01. Addr=0x3 LB -> 0xFFFF_FF80. LBU -> 0x0000_0080. Addr=0x2 LH -> 0xFFFF_80F0.
- SB/SH: SB Addr=0x5 Wdata=0x1234_56AB -> Mem_Addr=1, Be=0010, Mem_Wdata=0xABAB_ABAB, Store_Ready next cycle. SH Addr=0x2 -> Be=1100.
- Misaligned/illegal: LW Addr=0x2, and load funct3=3 -> no Mem_Re/We, Load_Valid one cycle after request, Misaligned=1, Rdata=0.
- Hold and latency: Store_Req held high 5 cycles after Store_Ready -> exactly one Mem_We. Rerun the LW case with MEM_LATENCY=4 -> Load_Valid 6 cycles after request. Assert reset during READ -> no Load_Valid.

Source files
------------

// File: rtl/datamem_ctrl.sv
// Data-memory controller between the control unit's load/store handshake and a
// single-port synchronous SRAM: RV32I lane steering, extension and misalignment.
module datamem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  DMC_Clk,
    input  logic                  DMC_Reset,
    input  logic                  DMC_Load_Req,
    input  logic                  DMC_Store_Req,
    input  logic [2:0]            DMC_Funct3,
    input  logic [31:0]           DMC_Addr,
    input  logic [31:0]           DMC_Wdata,
    output logic                  DMC_Load_Valid,
    output logic                  DMC_Store_Ready,
    output logic [31:0]           DMC_Rdata,
    output logic                  DMC_Misaligned,
    output logic [ADDR_WIDTH-1:0] DMC_Mem_Addr,
    output logic                  DMC_Mem_Re,
    output logic                  DMC_Mem_We,
    output logic [3:0]            DMC_Mem_Be,
    output logic [31:0]           DMC_Mem_Wdata,
    input  logic [31:0]           DMC_Mem_Rdata
);

    // state | meaning
    // IDLE  | wait for a load or store request
    // READ  | read strobe cycle, then latency down-counter to terminal count
    // WRITE | write strobe cycle
    // RESP  | response pulse cycle
    // HOLD  | wait for both requests to drop
    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WRITE, ST_RESP, ST_HOLD
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  load_valid_q, load_valid_d;
    logic                  store_ready_q, store_ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  misaligned_q, misaligned_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic        req_load, req_any, funct_legal, misal, req_ok, read_done;
    logic [31:0] load_ext;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^DMC_Addr[31:ADDR_WIDTH+2];

    // Load has priority; a store is only considered when no load is pending.
    assign req_load = DMC_Load_Req;
    assign req_any  = DMC_Load_Req | DMC_Store_Req;

    always_comb begin
        funct_legal = 1'b0;
        if (req_load) begin
            funct_legal = (DMC_Funct3 == 3'd0) || (DMC_Funct3 == 3'd1) ||
                          (DMC_Funct3 == 3'd2) || (DMC_Funct3 == 3'd4) ||
                          (DMC_Funct3 == 3'd5);
        end else begin
            funct_legal = (DMC_Funct3 == 3'd0) || (DMC_Funct3 == 3'd1) ||
                          (DMC_Funct3 == 3'd2);
        end
        misal  = ((DMC_Funct3[1:0] == 2'b01) && DMC_Addr[0]) ||
                 ((DMC_Funct3[1:0] == 2'b10) && (DMC_Addr[1:0] != 2'b00));
        req_ok = funct_legal && !misal;
    end

    // The strobe cycle itself does not count toward the SRAM latency.
    assign read_done = !mem_re_q && (cnt_q == 3'd0);

    always_comb begin
        logic [7:0]  rbyte;
        logic [15:0] rhalf;
        rbyte = DMC_Mem_Rdata[8*addr_lo_q +: 8];
        rhalf = addr_lo_q[1] ? DMC_Mem_Rdata[31:16] : DMC_Mem_Rdata[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{rbyte[7]}}, rbyte};
            3'd4:    load_ext = {24'd0, rbyte};
            3'd1:    load_ext = {{16{rhalf[15]}}, rhalf};
            3'd5:    load_ext = {16'd0, rhalf};
            default: load_ext = DMC_Mem_Rdata;
        endcase
    end

    always_ff @(posedge DMC_Clk) begin
        if (DMC_Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            addr_lo_q     <= 2'd0;
            funct3_q      <= 3'd0;
            load_valid_q  <= 1'b0;
            store_ready_q <= 1'b0;
            rdata_q       <= 32'd0;
            misaligned_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= 4'd0;
            mem_wdata_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_lo_q     <= addr_lo_d;
            funct3_q      <= funct3_d;
            load_valid_q  <= load_valid_d;
            store_ready_q <= store_ready_d;
            rdata_q       <= rdata_d;
            misaligned_q  <= misaligned_d;
            mem_addr_q    <= mem_addr_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (!req_ok)       state_d = ST_RESP;
                    else if (req_load) state_d = ST_READ;
                    else               state_d = ST_WRITE;
                end
            end
            ST_READ:  if (read_done) state_d = ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_HOLD;
            ST_HOLD:  if (!DMC_Load_Req && !DMC_Store_Req) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        addr_lo_d     = addr_lo_q;
        funct3_d      = funct3_q;
        load_valid_d  = 1'b0;
        store_ready_d = 1'b0;
        rdata_d       = rdata_q;
        misaligned_d  = misaligned_q;
        mem_addr_d    = mem_addr_q;
        mem_re_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_lo_d    = DMC_Addr[1:0];
                    funct3_d     = DMC_Funct3;
                    mem_addr_d   = DMC_Addr[ADDR_WIDTH+1:2];
                    rdata_d      = 32'd0;
                    misaligned_d = !req_ok;
                    if (!req_ok) begin
                        load_valid_d  = req_load;
                        store_ready_d = !req_load;
                    end else if (req_load) begin
                        mem_re_d = 1'b1;
                        cnt_d    = CNT_INIT;
                    end else begin
                        mem_we_d = 1'b1;
                        case (DMC_Funct3[1:0])
                            2'b00: begin
                                mem_be_d    = 4'b0001 << DMC_Addr[1:0];
                                mem_wdata_d = {4{DMC_Wdata[7:0]}};
                            end
                            2'b01: begin
                                mem_be_d    = DMC_Addr[1] ? 4'b1100 : 4'b0011;
                                mem_wdata_d = {2{DMC_Wdata[15:0]}};
                            end
                            default: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = DMC_Wdata;
                            end
                        endcase
                    end
                end
            end
            ST_READ: begin
                if (read_done) begin
                    rdata_d      = load_ext;
                    load_valid_d = 1'b1;
                end else if (!mem_re_q) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WRITE: store_ready_d = 1'b1;
            default: ;
        endcase
    end

    assign DMC_Load_Valid  = load_valid_q;
    assign DMC_Store_Ready = store_ready_q;
    assign DMC_Rdata       = rdata_q;
    assign DMC_Misaligned  = misaligned_q;
    assign DMC_Mem_Addr    = mem_addr_q;
    assign DMC_Mem_Re      = mem_re_q;
    assign DMC_Mem_We      = mem_we_q;
    assign DMC_Mem_Be      = mem_be_q;
    assign DMC_Mem_Wdata   = mem_wdata_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Scoreboard bench for datamem_ctrl: two instances (latency 1 and 4), each with
// its own behavioural SRAM; expected responses are queued when a request is driven.
module tb_datamem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        load_req  [2];
    logic        store_req [2];
    logic [2:0]  funct3    [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        load_valid[2];
    logic        store_ready[2];
    logic [31:0] rdata     [2];
    logic        misal     [2];
    logic [9:0]  mem_addr  [2];
    logic        mem_re    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [31:0] mem  [16];
        logic [31:0] pipe [LAT];

        always @(posedge clk) begin
            if (rst[g]) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
                mem[0] <= 32'h80F0_7F01;
                mem[2] <= 32'hDEAD_BEEF;
            end else if (mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) mem[mem_addr[g][3:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            pipe[0] <= mem_re[g] ? mem[mem_addr[g][3:0]] : 32'hBAD0_BAD0;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];

        datamem_ctrl #(.ADDR_WIDTH(10), .MEM_LATENCY(LAT)) u_dut (
            .DMC_Clk        (clk),
            .DMC_Reset      (rst[g]),
            .DMC_Load_Req   (load_req[g]),
            .DMC_Store_Req  (store_req[g]),
            .DMC_Funct3     (funct3[g]),
            .DMC_Addr       (addr[g]),
            .DMC_Wdata      (wdata[g]),
            .DMC_Load_Valid (load_valid[g]),
            .DMC_Store_Ready(store_ready[g]),
            .DMC_Rdata      (rdata[g]),
            .DMC_Misaligned (misal[g]),
            .DMC_Mem_Addr   (mem_addr[g]),
            .DMC_Mem_Re     (mem_re[g]),
            .DMC_Mem_We     (mem_we[g]),
            .DMC_Mem_Be     (mem_be[g]),
            .DMC_Mem_Wdata  (mem_wdata[g]),
            .DMC_Mem_Rdata  (mem_rdata[g])
        );
    end

    typedef struct {
        bit          ld;
        logic [31:0] rd;
        bit          mis;
        int          lat;
        int          strobes;
        logic [9:0]  maddr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run_req(input int d, input bit ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_mis, input int exp_lat,
                           input int exp_strobes, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input int hold_extra);
        exp_t e;
        int   n_re = 0, n_we = 0, pulses = 0, lat = -1;
        logic [9:0]  cap_addr = '0;
        logic [3:0]  cap_be = '0;
        logic [31:0] cap_wd = '0;
        e.ld = ld; e.rd = exp_rd; e.mis = exp_mis; e.lat = exp_lat;
        e.strobes = exp_strobes; e.maddr = a[11:2]; e.be = exp_be; e.wd = exp_wd;
        sb_q.push_back(e);
        load_req[d] = ld; store_req[d] = !ld; funct3[d] = f3; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_re[d]) begin n_re++; cap_addr = mem_addr[d]; end
            if (mem_we[d]) begin
                n_we++; cap_addr = mem_addr[d]; cap_be = mem_be[d]; cap_wd = mem_wdata[d];
            end
            if (load_valid[d] || store_ready[d]) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc;
                    e = sb_q.pop_front();
                    check_eq("kind", {30'd0, load_valid[d], store_ready[d]}, e.ld ? 32'd2 : 32'd1);
                    check_eq("latency", lat, e.lat);
                    check_eq("misaligned", {31'd0, misal[d]}, {31'd0, e.mis});
                    if (e.ld) check_eq("rdata", rdata[d], e.rd);
                end
            end
            if (lat >= 0 && cyc >= lat + hold_extra) break;
        end
        if (lat < 0) begin
            check_eq("timeout", 32'd1, 32'd0);
            e = sb_q.pop_front();
        end
        load_req[d] = 1'b0; store_req[d] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (load_valid[d] || store_ready[d]) pulses++;
            if (mem_re[d]) n_re++;
            if (mem_we[d]) n_we++;
        end
        check_eq("pulses", pulses, 1);
        check_eq("re_count", n_re, e.ld ? e.strobes : 0);
        check_eq("we_count", n_we, e.ld ? 0 : e.strobes);
        if (n_re + n_we > 0) check_eq("mem_addr", {22'd0, cap_addr}, {22'd0, e.maddr});
        if (n_we > 0) begin
            check_eq("be", {28'd0, cap_be}, {28'd0, e.be});
            check_eq("wdata", cap_wd, e.wd);
        end
    endtask

    initial begin
        int nv;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; load_req[d] = 1'b0; store_req[d] = 1'b0;
            funct3[d] = 3'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
        end
        load_req[0] = 1'b1; funct3[0] = 3'd2; addr[0] = 32'h8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flags", {27'd0, load_valid[0], store_ready[0], mem_re[0], mem_we[0], misal[0]}, 32'd0);
        check_eq("rst_rdata", rdata[0], 32'd0);
        check_eq("rst_maddr", {22'd0, mem_addr[0]}, 32'd0);
        check_eq("rst_be", {28'd0, mem_be[0]}, 32'd0);
        check_eq("rst_wdata", mem_wdata[0], 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // LW at word 2, request already held from reset
        run_req(0, 1, 3'd2, 32'h8, 0, 32'hDEAD_BEEF, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd0, 32'h3, 0, 32'hFFFF_FF80, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd4, 32'h3, 0, 32'h0000_0080, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd1, 32'h2, 0, 32'hFFFF_80F0, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd5, 32'h0, 0, 32'h0000_7F01, 0, 3, 1, 4'd0, 0, 0);
        // misaligned / illegal loads and store
        run_req(0, 1, 3'd2, 32'h2, 0, 32'h0, 1, 1, 0, 4'd0, 0, 0);
        run_req(0, 1, 3'd3, 32'h0, 0, 32'h0, 1, 1, 0, 4'd0, 0, 0);
        run_req(0, 0, 3'd1, 32'h1, 32'h1111_2222, 32'h0, 1, 1, 0, 4'd0, 0, 0);
        // stores; SB held 5 cycles past the response
        run_req(0, 0, 3'd0, 32'h5, 32'h1234_56AB, 0, 0, 2, 1, 4'b0010, 32'hABAB_ABAB, 5);
        run_req(0, 0, 3'd1, 32'h2, 32'h1234_56AB, 0, 0, 2, 1, 4'b1100, 32'h56AB_56AB, 0);
        run_req(0, 0, 3'd2, 32'hC, 32'hCAFE_F00D, 0, 0, 2, 1, 4'b1111, 32'hCAFE_F00D, 0);
        run_req(0, 1, 3'd2, 32'h0, 0, 32'h56AB_7F01, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd2, 32'h4, 0, 32'h0000_AB00, 0, 3, 1, 4'd0, 0, 0);
        run_req(0, 1, 3'd2, 32'hC, 0, 32'hCAFE_F00D, 0, 3, 1, 4'd0, 0, 0);

        // latency 4 instance
        run_req(1, 1, 3'd2, 32'h8, 0, 32'hDEAD_BEEF, 0, 6, 1, 4'd0, 0, 0);
        run_req(1, 1, 3'd0, 32'h1, 0, 32'h0000_007F, 0, 6, 1, 4'd0, 0, 0);

        // reset during READ abandons the load
        nv = 0;
        load_req[1] = 1'b1; funct3[1] = 3'd2; addr[1] = 32'h8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        load_req[1] = 1'b0;
        repeat (3) begin @(negedge clk); if (load_valid[1]) nv++; end
        rst[1] = 1'b0;
        repeat (8) begin @(negedge clk); if (load_valid[1]) nv++; end
        check_eq("abort_no_valid", nv, 0);
        check_eq("abort_rdata", rdata[1], 32'd0);
        run_req(1, 1, 3'd2, 32'h8, 0, 32'hDEAD_BEEF, 0, 6, 1, 4'd0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
